// File: rtl/lcd_pkg.sv
// Shared types, default timing and opcode constants for the HD44780-style bus driver.
package lcd_pkg;

  localparam int unsigned DEF_SETUP_CYC  = 3;
  localparam int unsigned DEF_EN_CYC     = 12;
  localparam int unsigned DEF_HOLD_CYC   = 2;
  localparam int unsigned DEF_EXEC_CYC   = 2000;
  localparam int unsigned DEF_LONG_CYC   = 82000;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  // Floor on the shared timer width so the default long wait always fits.
  localparam int unsigned MIN_CNT_W = 17;
  localparam int unsigned CMD_W     = 9;

  localparam logic [7:0] OP_CLEAR    = 8'h01;
  localparam logic [7:0] OP_HOME     = 8'h02;
  localparam logic [7:0] OP_HOME_ALT = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ENABLE = 3'd2,
    S_HOLD   = 3'd3,
    S_WAIT   = 3'd4
  } lcd_state_e;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_cmd_t;

  // Clear/home instructions need the long execution wait.
  function automatic logic is_long_cmd(input lcd_cmd_t cmd);
    return !cmd.rs && ((cmd.data == OP_CLEAR) || (cmd.data == OP_HOME) ||
                       (cmd.data == OP_HOME_ALT));
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Command queue: power-of-two deep synchronous FIFO with occupancy output.
module lcd_cmd_fifo
  import lcd_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned WIDTH = CMD_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic [WIDTH-1:0]        i_data,
  input  logic                    i_pop,
  output logic [WIDTH-1:0]        o_head_c,
  output logic [$clog2(DEPTH):0]  o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;

  // Entry storage; contents need no reset because the level gates every read.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally at the power-of-two depth; level tracks push minus pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= r_level + LW'(i_push) - LW'(i_pop);
    end
  end

  assign o_head_c = r_mem[r_rd_ptr];
  assign o_level  = r_level;

endmodule

// File: rtl/lcd_bus_driver.sv
// Queues command bytes and replays each as a timed write strobe on an HD44780-style bus.
module lcd_bus_driver
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = DEF_SETUP_CYC,
  parameter int unsigned EN_CYC     = DEF_EN_CYC,
  parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC,
  parameter int unsigned EXEC_CYC   = DEF_EXEC_CYC,
  parameter int unsigned LONG_CYC   = DEF_LONG_CYC,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_data,
  input  logic                         in_rs,
  output logic [7:0]                   lcd_data,
  output logic                         lcd_rs,
  output logic                         lcd_rw,
  output logic                         lcd_en,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int unsigned LVL_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned MAX_WAIT = (LONG_CYC > EXEC_CYC) ? LONG_CYC : EXEC_CYC;
  localparam int unsigned CNT_W    = ($clog2(MAX_WAIT) > MIN_CNT_W) ? $clog2(MAX_WAIT) : MIN_CNT_W;

  lcd_state_e       r_state;
  lcd_state_e       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_cnt_zero;

  lcd_cmd_t         r_bus;
  lcd_cmd_t         w_bus_next;
  lcd_cmd_t         w_head;
  logic             r_lcd_en;
  logic             w_lcd_en_next;
  logic             r_busy;
  logic             w_busy_next;
  logic             r_in_ready;
  logic             w_in_ready_next;

  logic             w_push;
  logic             w_pop;
  logic [LVL_W-1:0] w_level;
  logic [LVL_W-1:0] w_level_next;

  // Handshake uses the registered ready, so a push into a full queue cannot occur.
  assign w_push       = in_valid && r_in_ready;
  assign w_pop        = (r_state == S_IDLE) && (w_level != '0);
  assign w_level_next = w_level + LVL_W'(w_push) - LVL_W'(w_pop);
  assign w_cnt_zero   = (r_cnt == '0);

  lcd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_push   (w_push),
    .i_data   ({in_rs, in_data}),
    .i_pop    (w_pop),
    .o_head_c (w_head),
    .o_level  (w_level)
  );

  // State register and shared phase timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next state; the timer is loaded with N-1 on each phase entry and the phase exits at zero.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = w_cnt_zero ? '0 : (r_cnt - CNT_W'(1));
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_state_next = S_SETUP;
          w_cnt_next   = CNT_W'(SETUP_CYC - 1);
        end
      end
      S_SETUP: begin
        if (w_cnt_zero) begin
          w_state_next = S_ENABLE;
          w_cnt_next   = CNT_W'(EN_CYC - 1);
        end
      end
      S_ENABLE: begin
        if (w_cnt_zero) begin
          w_state_next = S_HOLD;
          w_cnt_next   = CNT_W'(HOLD_CYC - 1);
        end
      end
      S_HOLD: begin
        if (w_cnt_zero) begin
          w_state_next = S_WAIT;
          w_cnt_next   = is_long_cmd(r_bus) ? CNT_W'(LONG_CYC - 1) : CNT_W'(EXEC_CYC - 1);
        end
      end
      S_WAIT: begin
        if (w_cnt_zero) w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Output next values; the bus only changes on a pop so it is frozen through the strobe.
  always_comb begin
    w_bus_next      = r_bus;
    if (w_pop) w_bus_next = w_head;
    w_lcd_en_next   = (w_state_next == S_ENABLE);
    w_busy_next     = (w_state_next != S_IDLE) || (w_level_next != '0);
    w_in_ready_next = (w_level_next < LVL_W'(FIFO_DEPTH));
  end

  // Registered outputs so the strobe and flags are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus      <= '0;
      r_lcd_en   <= 1'b0;
      r_busy     <= 1'b0;
      r_in_ready <= 1'b0;
    end else begin
      r_bus      <= w_bus_next;
      r_lcd_en   <= w_lcd_en_next;
      r_busy     <= w_busy_next;
      r_in_ready <= w_in_ready_next;
    end
  end

  assign lcd_data   = r_bus.data;
  assign lcd_rs     = r_bus.rs;
  assign lcd_rw     = 1'b0;
  assign lcd_en     = r_lcd_en;
  assign busy       = r_busy;
  assign in_ready   = r_in_ready;
  assign fifo_level = w_level;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Self-checking bench for lcd_bus_driver with shortened execution waits.
module tb_lcd_bus_driver;

  localparam int unsigned SETUP = 3;
  localparam int unsigned EN    = 12;
  localparam int unsigned HOLD  = 2;
  localparam int unsigned EXEC  = 40;
  localparam int unsigned LONG  = 300;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_rs = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_ready;
  logic [7:0]       lcd_data;
  logic             lcd_rs;
  logic             lcd_rw;
  logic             lcd_en;
  logic             busy;
  logic [LVL_W-1:0] fifo_level;

  always #5 clk = ~clk;

  lcd_bus_driver #(
    .SETUP_CYC  (SETUP),
    .EN_CYC     (EN),
    .HOLD_CYC   (HOLD),
    .EXEC_CYC   (EXEC),
    .LONG_CYC   (LONG),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_rs      (in_rs),
    .lcd_data   (lcd_data),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_en     (lcd_en),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  typedef logic [8:0] cmd_t;  // {rs, data}

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         exp_wait;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Transaction-level reference: queue contents plus the edge windows of the current transfer.
  cmd_t mq[$];
  int   m_free, m_rise, m_fall, m_ret;
  cmd_t m_bus;
  logic m_ready;

  // Observed bus activity.
  logic prev_en = 1'b0, prev_busy = 1'b0, prev_ready = 1'b0;
  cmd_t prev_bus = '0;
  int   rise_cyc = -1, fall_cyc = -1, bfall_cyc = -1;
  int   n_rise = 0, dut_acc = 0;
  cmd_t emitted[$];

  function automatic bit is_long(input cmd_t c);
    return (c[8] == 1'b0) && (c[7:0] >= 8'h01) && (c[7:0] <= 8'h03);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // One clock: advance the model over the edge, then compare every output #1 later.
  task automatic step();
    bit pop, push, acc;
    acc = in_valid && prev_ready && !rst;
    @(posedge clk);
    cyc++;
    if (rst) begin
      mq.delete();
      m_ready = 1'b0;
      m_free  = cyc + 1;
      m_rise  = -1;
      m_fall  = -1;
      m_ret   = cyc;
      m_bus   = '0;
    end else begin
      pop  = (cyc >= m_free) && (mq.size() != 0);
      push = in_valid && m_ready;
      if (pop) begin
        m_bus  = mq.pop_front();
        m_rise = cyc + SETUP;
        m_fall = m_rise + EN;
        m_ret  = m_fall + HOLD + (is_long(m_bus) ? LONG : EXEC);
        m_free = m_ret + 1;
      end
      if (push) mq.push_back({in_rs, in_data});
      m_ready = (mq.size() < DEPTH);
    end
    if (acc) dut_acc++;
    #1;
    chk("lcd_en", int'(lcd_en), int'(cyc >= m_rise && cyc < m_fall));
    chk("lcd_bus", int'({lcd_rs, lcd_data}), int'(m_bus));
    chk("lcd_rw", int'(lcd_rw), 0);
    chk("busy", int'(busy), int'((cyc < m_ret) || (mq.size() != 0)));
    chk("in_ready", int'(in_ready), int'(m_ready));
    chk("fifo_level", int'(fifo_level), mq.size());
    if (prev_en && lcd_en) chk("bus_stable_en", int'({lcd_rs, lcd_data}), int'(prev_bus));
    if (lcd_en && !prev_en) begin
      rise_cyc = cyc;
      n_rise++;
      emitted.push_back({lcd_rs, lcd_data});
    end
    if (!lcd_en && prev_en) fall_cyc = cyc;
    if (!busy && prev_busy) bfall_cyc = cyc;
    prev_en    = lcd_en;
    prev_busy  = busy;
    prev_ready = in_ready;
    prev_bus   = {lcd_rs, lcd_data};
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    chk("rst_en", int'(lcd_en), 0);
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_data", int'(lcd_data), 0);
    step();
    rst = 1'b0;
    step();
    chk("ready_after_rst", int'(in_ready), 1);
  endtask

  task automatic drain(input int limit);
    bit done;
    done = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (cyc >= m_ret + 2 && mq.size() == 0) begin
        done = 1'b1;
        break;
      end
      step();
    end
    chk("drain_in_time", int'(done), 1);
  endtask

  task automatic push_one(input logic rs, input logic [7:0] d);
    in_valid = 1'b1;
    in_rs    = rs;
    in_data  = d;
    step();
  endtask

  vec_t vecs[8];

  initial begin
    int acc_cyc, n0;
    vecs[0] = '{1'b1, 8'h41, EXEC};
    vecs[1] = '{1'b0, 8'h01, LONG};
    vecs[2] = '{1'b0, 8'h38, EXEC};
    vecs[3] = '{1'b0, 8'h02, LONG};
    vecs[4] = '{1'b0, 8'h03, LONG};
    vecs[5] = '{1'b1, 8'h01, EXEC};
    vecs[6] = '{1'b0, 8'h00, EXEC};
    vecs[7] = '{1'b0, 8'h04, EXEC};

    // Single writes: latency, strobe width, execution wait and bus value.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      rise_cyc = -1; fall_cyc = -1; bfall_cyc = -1;
      emitted.delete();
      push_one(vecs[v].rs, vecs[v].data);
      acc_cyc = cyc;
      in_valid = 1'b0;
      drain(LONG + 100);
      chk("vec_latency", rise_cyc - acc_cyc, 1 + SETUP);
      chk("vec_en_width", fall_cyc - rise_cyc, EN);
      chk("vec_wait", bfall_cyc - fall_cyc - HOLD, vecs[v].exp_wait);
      chk("vec_count", emitted.size(), 1);
      if (emitted.size() == 1) chk("vec_bus", int'(emitted[0]), int'({vecs[v].rs, vecs[v].data}));
    end

    // Full queue: valid held for 10 cycles while the first byte is in flight.
    do_reset();
    emitted.delete();
    dut_acc = 0;
    for (int k = 0; k < 10; k++) push_one(1'b1, 8'(8'h50 + k));
    in_valid = 1'b0;
    chk("full_level", int'(fifo_level), 4);
    chk("full_ready", int'(in_ready), 0);
    chk("full_accepts", dut_acc, 5);
    drain(6 * 80);
    chk("full_emitted", emitted.size(), 5);
    for (int i = 0; i < 5 && i < emitted.size(); i++)
      chk("full_order", int'(emitted[i]), 256 + 8'h50 + i);

    // Push coinciding with a pop at level 2.
    do_reset();
    emitted.delete();
    push_one(1'b1, 8'hA0);
    push_one(1'b1, 8'hA1);
    push_one(1'b1, 8'hA2);
    in_valid = 1'b0;
    for (int i = 0; i < 200 && (cyc + 1 != m_free); i++) step();
    chk("pp_level_before", int'(fifo_level), 2);
    push_one(1'b1, 8'hA3);
    in_valid = 1'b0;
    chk("pp_level_after", int'(fifo_level), 2);
    drain(6 * 80);
    chk("pp_emitted", emitted.size(), 4);
    for (int i = 0; i < 4 && i < emitted.size(); i++)
      chk("pp_order", int'(emitted[i]), 256 + 8'hA0 + i);

    // Reset in the 5th enable cycle with 3 bytes queued.
    do_reset();
    for (int k = 0; k < 4; k++) push_one(1'b1, 8'(8'h60 + k));
    in_valid = 1'b0;
    for (int i = 0; i < 50 && cyc < m_rise + 4; i++) step();
    chk("mid_level", int'(fifo_level), 3);
    chk("mid_en", int'(lcd_en), 1);
    rst = 1'b1;
    step();
    chk("mid_rst_en", int'(lcd_en), 0);
    chk("mid_rst_level", int'(fifo_level), 0);
    rst = 1'b0;
    n0 = n_rise;
    for (int i = 0; i < 400; i++) step();
    chk("mid_no_pulse", n_rise - n0, 0);

    // Random traffic against the reference model, with occasional resets.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      in_valid = ($urandom_range(0, 7) == 0);
      in_rs    = 1'($urandom_range(0, 1));
      in_data  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      rst      = ($urandom_range(0, 1499) == 0);
      step();
    end
    rst = 1'b0;
    drain(DEPTH * (LONG + 40) + 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
